ahb_timer: RTL and testbench

AHB_TIMER -- requirements
Module: ahb_timer

---
 rtl/ahb_timer_if.sv | 28 ++
 rtl/ahb_timer.sv | 130 +++++++++++++
 tb/tb_ahb_timer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_timer_if.sv
// AHB-Lite slave-side bundle for the timer: select, address/data-phase inputs
// and the slave response.
interface ahb_timer_if;
   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [1:0]  trans;
      logic [2:0]  burst;
      logic [3:0]  prot;
      logic        mastlock;
      logic        ready;
      logic [31:0] wdata;
   } bus_slv_in;

   typedef struct packed {
      logic [31:0] rdata;
      logic        ready;
      logic        resp;
   } bus_slv_out;

   logic       sel;
   bus_slv_in  slv_in;
   bus_slv_out slv_out;

   modport master (output sel, slv_in, input slv_out);
   modport slave  (input sel, slv_in, output slv_out);
endinterface

// File: rtl/ahb_timer.sv
// AHB-Lite programmable timer: prescaler, 32-bit counter with compare match,
// sticky MATCH flag and level interrupt. Illegal accesses get a two-cycle ERROR.
module ahb_timer #(
   parameter int          PRESCALE_W    = 16,
   parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   ahb_timer_if.slave  bus,
   output logic        irq
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_t;
   localparam logic [PRESCALE_W-1:0] P_ONE = 1;

   state_t                state;
   logic                  ready_q, resp_q;
   logic [2:0]            a_off;
   logic                  a_write;
   logic [2:0]            ctrl;
   logic [PRESCALE_W-1:0] prescale, pcnt;
   logic [31:0]           count, compare, rdata;
   logic                  match;
   logic                  accept, legal, we, tick, hit;
   logic                  wr_ctrl, wr_pre, wr_count, wr_cmp, wr_status;
   logic                  unused_bits;

   assign accept = bus.sel && bus.slv_in.trans[1] && bus.slv_in.ready && (state != S_ERR1);
   assign legal  = (bus.slv_in.size == 3'b010) && (bus.slv_in.addr[1:0] == 2'b00) &&
                   (bus.slv_in.addr[4:2] <= 3'd4);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         ready_q <= 1'b1;
         resp_q  <= 1'b0;
         a_off   <= '0;
         a_write <= 1'b0;
      end else begin
         if (accept) begin
            a_off   <= bus.slv_in.addr[4:2];
            a_write <= bus.slv_in.write;
         end
         unique case (state)
            S_ERR1: begin
               state   <= S_ERR2;
               ready_q <= 1'b1;
               resp_q  <= 1'b1;
            end
            default: begin
               if (accept && legal) begin
                  state   <= S_ACCESS;
                  ready_q <= 1'b1;
                  resp_q  <= 1'b0;
               end else if (accept) begin
                  state   <= S_ERR1;
                  ready_q <= 1'b0;
                  resp_q  <= 1'b1;
               end else begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
                  resp_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign we        = (state == S_ACCESS) && a_write;
   assign wr_ctrl   = we && (a_off == 3'd0);
   assign wr_pre    = we && (a_off == 3'd1);
   assign wr_count  = we && (a_off == 3'd2);
   assign wr_cmp    = we && (a_off == 3'd3);
   assign wr_status = we && (a_off == 3'd4);
   assign tick      = ctrl[0] && (pcnt == prescale);
   // A bus write to COUNT on a tick suppresses the compare for that cycle.
   assign hit       = tick && !wr_count && (count == compare);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl     <= '0;
         prescale <= '0;
         pcnt     <= '0;
         count    <= '0;
         compare  <= RESET_COMPARE;
         match    <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl <= bus.slv_in.wdata[2:0];
         if (wr_pre)  prescale <= bus.slv_in.wdata[PRESCALE_W-1:0];
         if (wr_cmp)  compare <= bus.slv_in.wdata;

         if (wr_pre || (wr_ctrl && ctrl[0] && !bus.slv_in.wdata[0])) pcnt <= '0;
         else if (tick)                                              pcnt <= '0;
         else if (ctrl[0])                                           pcnt <= pcnt + P_ONE;

         if (wr_count)          count <= bus.slv_in.wdata;
         else if (hit && ctrl[2]) count <= '0;
         else if (tick)         count <= count + 32'd1;

         // Set beats a coincident write-1-to-clear.
         if (hit)                                    match <= 1'b1;
         else if (wr_status && bus.slv_in.wdata[0])  match <= 1'b0;

         irq <= match & ctrl[1];
      end
   end

   always_comb begin
      rdata = '0;
      if ((state == S_ACCESS) && !a_write) begin
         case (a_off)
            3'd0:    rdata = {29'b0, ctrl};
            3'd1:    rdata = 32'(prescale);
            3'd2:    rdata = count;
            3'd3:    rdata = compare;
            3'd4:    rdata = {31'b0, match};
            default: rdata = '0;
         endcase
      end
   end

   always_comb begin
      bus.slv_out.rdata = rdata;
      bus.slv_out.ready = ready_q;
      bus.slv_out.resp  = resp_q;
   end

   assign unused_bits = ^{bus.slv_in.addr[31:5], bus.slv_in.burst, bus.slv_in.prot,
                          bus.slv_in.mastlock};
endmodule

// File: tb/tb_ahb_timer.sv
// Directed bench for ahb_timer: a cycle model built from the register/timer rules
// is compared every cycle, with hand-computed literal read values on top.
module tb_ahb_timer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic irq;

   ahb_timer_if bus();

   ahb_timer #(.PRESCALE_W(16), .RESET_COMPARE(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst(rst), .bus(bus), .irq(irq)
   );

   always #5 clk = ~clk;

   logic        t_sel, t_write;
   logic [31:0] t_addr, t_wdata;
   logic [2:0]  t_size;
   logic [1:0]  t_trans;

   // Single slave on the bus: HREADY in is our own HREADYOUT.
   always_comb begin
      bus.sel             = t_sel;
      bus.slv_in.write    = t_write;
      bus.slv_in.addr     = t_addr;
      bus.slv_in.size     = t_size;
      bus.slv_in.trans    = t_trans;
      bus.slv_in.burst    = 3'b000;
      bus.slv_in.prot     = 4'b0011;
      bus.slv_in.mastlock = 1'b0;
      bus.slv_in.wdata    = t_wdata;
      bus.slv_in.ready    = bus.slv_out.ready;
   end

   int total = 0;
   int bad   = 0;

   // Model state. Data phase: 0 none, 1 OKAY access, 2 first error cycle, 3 second.
   logic [2:0]  m_ctrl;
   logic [15:0] m_pre, m_pcnt;
   logic [31:0] m_cnt, m_cmp;
   logic        m_match, m_irq, m_wr;
   int          m_ph;
   logic [2:0]  m_off;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] reg_value(input logic [2:0] o);
      case (o)
         3'd0:    return {29'b0, m_ctrl};
         3'd1:    return {16'b0, m_pre};
         3'd2:    return m_cnt;
         3'd3:    return m_cmp;
         3'd4:    return {31'b0, m_match};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      logic wen, tk, hit, take, ok;
      if (!rst) begin
         m_ctrl = 0; m_pre = 0; m_pcnt = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
         m_match = 0; m_irq = 0; m_ph = 0; m_wr = 0; m_off = 0;
         return;
      end
      wen  = (m_ph == 1) && m_wr;
      tk   = m_ctrl[0] && (m_pcnt == m_pre);
      hit  = tk && !(wen && m_off == 2) && (m_cnt == m_cmp);
      take = t_sel && (t_trans >= 2) && (m_ph != 2);
      ok   = (t_size == 3'd2) && (t_addr[1:0] == 0) && (t_addr[4:2] < 5);
      m_irq = m_match && m_ctrl[1];
      if (wen && m_off == 4 && t_wdata[0]) m_match = 0;
      if (hit) m_match = 1;
      if (wen && m_off == 2)    m_cnt = t_wdata;
      else if (hit && m_ctrl[2]) m_cnt = 0;
      else if (tk)              m_cnt = m_cnt + 1;
      if (tk) m_pcnt = 0;
      else if (m_ctrl[0]) m_pcnt = m_pcnt + 1;
      if ((wen && m_off == 1) || (wen && m_off == 0 && m_ctrl[0] && !t_wdata[0])) m_pcnt = 0;
      if (wen && m_off == 0) m_ctrl = t_wdata[2:0];
      if (wen && m_off == 1) m_pre  = t_wdata[15:0];
      if (wen && m_off == 3) m_cmp  = t_wdata;
      m_ph = (m_ph == 2) ? 3 : (take ? (ok ? 1 : 2) : 0);
      if (take) begin
         m_off = t_addr[4:2];
         m_wr  = t_write;
      end
   endtask

   task automatic check_outputs();
      logic [31:0] er;
      er = 32'h0;
      if (m_ph == 1 && !m_wr) er = reg_value(m_off);
      chk("ready", bus.slv_out.ready, (m_ph != 2));
      chk("resp",  bus.slv_out.resp,  (m_ph >= 2));
      chk("rdata", bus.slv_out.rdata, er);
      chk("irq",   irq,               m_irq);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle();
      t_sel = 0; t_trans = 2'd0; t_write = 0; t_addr = 0; t_size = 3'd2;
   endtask

   task automatic addr_ph(input logic w, input logic [31:0] a, input logic [2:0] sz);
      t_sel = 1; t_trans = 2'd2; t_write = w; t_addr = a; t_size = sz;
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] val);
      addr_ph(1'b1, {27'b0, off, 2'b00}, 3'd2);
      cyc();
      t_wdata = val;
      idle();
      cyc();
   endtask

   task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string nm);
      addr_ph(1'b0, {27'b0, off, 2'b00}, 3'd2);
      cyc();
      chk(nm, bus.slv_out.rdata, exp);
      idle();
   endtask

   task automatic err(input logic w, input logic [31:0] a, input logic [2:0] sz, input string nm);
      addr_ph(w, a, sz);
      cyc();
      chk({nm, "_c1_ready"}, bus.slv_out.ready, 1'b0);
      chk({nm, "_c1_resp"},  bus.slv_out.resp,  1'b1);
      idle();
      cyc();
      chk({nm, "_c2_ready"}, bus.slv_out.ready, 1'b1);
      chk({nm, "_c2_resp"},  bus.slv_out.resp,  1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      t_wdata = 0;
      rst = 0;
      repeat (3) cyc();
      chk("rst_ready", bus.slv_out.ready, 1'b1);
      chk("rst_rdata", bus.slv_out.rdata, 32'h0);
      chk("rst_irq", irq, 1'b0);
      rst = 1;
      rd(3'd3, 32'hFFFF_FFFF, "rst_compare");
      rd(3'd0, 32'h0, "rst_ctrl");
      rd(3'd2, 32'h0, "rst_count");

      // Compare 5, prescale 0, auto-reload with interrupt.
      wr(3'd3, 32'd5);
      wr(3'd1, 32'd0);
      wr(3'd0, 32'd7);
      rd(3'd2, 32'd1, "m5_cnt1");
      rd(3'd2, 32'd2, "m5_cnt2");
      repeat (3) cyc();
      rd(3'd4, 32'd1, "m5_match");
      chk("m5_irq_lag", irq, 1'b0);
      cyc();
      chk("m5_irq", irq, 1'b1);
      rd(3'd2, 32'd2, "m5_reload");
      wr(3'd0, 32'd0);
      rd(3'd2, 32'd4, "freeze");
      chk("irq_en_off", irq, 1'b0);
      cyc();
      rd(3'd2, 32'd4, "frozen2");
      wr(3'd4, 32'd1);
      rd(3'd4, 32'd0, "status_w1c");

      // Prescale 3: one increment every 4 cycles.
      wr(3'd1, 32'd3);
      wr(3'd2, 32'd0);
      wr(3'd0, 32'd1);
      rd(3'd2, 32'd0, "p3_c0");
      cyc();
      rd(3'd2, 32'd0, "p3_c0b");
      rd(3'd2, 32'd1, "p3_c1");
      repeat (3) cyc();
      rd(3'd2, 32'd2, "p3_c2");
      wr(3'd0, 32'd0);

      // Error responses leave registers alone.
      wr(3'd0, 32'd6);
      err(1'b0, 32'h14, 3'd2, "off14");
      err(1'b0, 32'h00, 3'd1, "hsize16");
      err(1'b1, 32'h0A, 3'd2, "misalign");
      rd(3'd2, 32'd2, "err_nochg");
      rd(3'd0, 32'd6, "ctrl_after_err");

      // Transfer held through ERR1 is taken at the end of ERR2.
      addr_ph(1'b0, 32'h14, 3'd2);
      cyc();
      chk("hold_err1", bus.slv_out.ready, 1'b0);
      addr_ph(1'b0, 32'h00, 3'd2);
      cyc();
      chk("hold_err2", bus.slv_out.resp, 1'b1);
      cyc();
      chk("hold_rd", bus.slv_out.rdata, 32'd6);
      chk("hold_ok", bus.slv_out.resp, 1'b0);
      idle();

      // Back-to-back write then read of CTRL.
      addr_ph(1'b1, 32'h0, 3'd2);
      cyc();
      t_wdata = 32'd2;
      addr_ph(1'b0, 32'h0, 3'd2);
      cyc();
      chk("b2b_rd", bus.slv_out.rdata, 32'd2);
      chk("b2b_ready", bus.slv_out.ready, 1'b1);
      idle();
      cyc();

      // Wrap from FFFFFFFF, compare 0, no auto-reload.
      wr(3'd1, 32'd0);
      wr(3'd2, 32'hFFFF_FFFF);
      wr(3'd3, 32'd0);
      wr(3'd0, 32'd3);
      rd(3'd2, 32'd0, "wrap0");
      rd(3'd4, 32'd1, "wrap_match");
      chk("wrap_irq_lag", irq, 1'b0);
      rd(3'd2, 32'd2, "wrap_cnt2");
      chk("wrap_irq", irq, 1'b1);
      wr(3'd4, 32'd1);
      cyc();
      chk("irq_clr", irq, 1'b0);
      rd(3'd4, 32'd0, "match_clr");

      // COUNT write on a tick wins; MATCH set wins over coincident clear.
      wr(3'd3, 32'h102);
      wr(3'd2, 32'h100);
      rd(3'd2, 32'h101, "cnt_wr_wins");
      wr(3'd4, 32'd1);
      rd(3'd4, 32'd1, "set_wins");

      // Reset during ERR1.
      addr_ph(1'b0, 32'h14, 3'd2);
      cyc();
      chk("pre_rst_err1", bus.slv_out.ready, 1'b0);
      idle();
      rst = 0;
      #1;
      chk("arst_ready", bus.slv_out.ready, 1'b1);
      chk("arst_resp", bus.slv_out.resp, 1'b0);
      chk("arst_rdata", bus.slv_out.rdata, 32'h0);
      chk("arst_irq", irq, 1'b0);
      cyc();
      cyc();
      rst = 1;
      rd(3'd3, 32'hFFFF_FFFF, "post_rst_cmp");
      chk("post_rst_resp", bus.slv_out.resp, 1'b0);
      rd(3'd0, 32'h0, "post_rst_ctrl");
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
